// File: rtl/tx_axis_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer feeding the 32-bit TX MAC.
// A frame is released only after its tlast beat is stored; frames that do not fit are dropped whole.
module tx_axis_frame_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
    input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    input  logic                   s00_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
    output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic                   m00_axis_tlast,
    output logic                   frame_dropped,
    output logic [ADDR_W:0]        frames_stored
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + DATA_NBYTES + 1;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StAccept, StDiscard} wr_state_e;

    wr_state_e wr_state;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] commit_ptr;
    logic [ADDR_W:0] commit_rd;
    logic [ADDR_W:0] rd_ptr;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_data_q;
    logic               rd_valid_q;

    logic [ENTRY_W-1:0] skid_q [2];
    logic               skid_wp;
    logic               skid_rp;
    logic [1:0]         skid_cnt;

    logic       s_hs;
    logic       full;
    logic       mem_we;
    logic       commit_evt;
    logic       pop;
    logic       pop_last;
    logic       rd_en;
    logic [2:0] occ_next;

    assign s00_axis_tready = !reset;
    assign s_hs = s00_axis_tvalid && s00_axis_tready;
    assign full = (wr_ptr - rd_ptr) == PTR_DEPTH;
    assign mem_we = s_hs && (wr_state == StAccept) && !full;
    assign commit_evt = mem_we && s00_axis_tlast;

    assign m00_axis_tvalid = skid_cnt != 2'd0;
    assign {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} = skid_q[skid_rp];
    assign pop = m00_axis_tvalid && m00_axis_tready;
    assign pop_last = pop && m00_axis_tlast;

    // Occupancy the skid will have once the in-flight RAM read lands; leave room for one more.
    assign occ_next = 3'(skid_cnt) + 3'(rd_valid_q) - 3'(pop);
    assign rd_en = (rd_ptr != commit_rd) && (occ_next < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state      <= StAccept;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= 1'b0;
            if (s_hs) begin
                unique case (wr_state)
                    StAccept: begin
                        if (full) begin
                            wr_ptr        <= commit_ptr;
                            frame_dropped <= 1'b1;
                            if (!s00_axis_tlast) begin
                                wr_state <= StDiscard;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (s00_axis_tlast) begin
                                commit_ptr <= wr_ptr + PTR_ONE;
                            end
                        end
                    end
                    StDiscard: begin
                        if (s00_axis_tlast) begin
                            wr_state <= StAccept;
                        end
                    end
                    default: wr_state <= StAccept;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    // Read side sees commits one cycle late, which sets the tlast-to-tvalid latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_rd  <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            commit_rd  <= commit_ptr;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            skid_wp   <= 1'b0;
            skid_rp   <= 1'b0;
            skid_cnt  <= 2'd0;
        end else begin
            if (rd_valid_q) begin
                skid_q[skid_wp] <= rd_data_q;
                skid_wp         <= !skid_wp;
            end
            if (pop) begin
                skid_rp <= !skid_rp;
            end
            unique case ({rd_valid_q, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_stored <= '0;
        end else begin
            unique case ({commit_evt, pop_last})
                2'b10:   frames_stored <= frames_stored + PTR_ONE;
                2'b01:   frames_stored <= frames_stored - PTR_ONE;
                default: frames_stored <= frames_stored;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_axis_frame_buffer.sv
// Directed bench for tx_axis_frame_buffer (DEPTH=16): latency, gap-free output, drops, stalls,
// reset recovery and exact-fill behaviour, with an output scoreboard.
module tb_tx_axis_frame_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        frame_dropped;
    logic [4:0]  frames_stored;

    int n_checks = 0;
    int n_fail = 0;
    int n_drops = 0;
    int tot = 0;
    bit rand_rdy = 1'b0;
    logic [36:0] exp_q[$];

    tx_axis_frame_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tkeep  (m_tkeep),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast),
        .frame_dropped   (frame_dropped),
        .frames_stored   (frames_stored)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard, gap detector and stall-stability checker.
    logic        in_frame = 1'b0;
    logic        prev_stall = 1'b0;
    logic [36:0] prev_beat = '0;
    wire  [36:0] beat = {m_tlast, m_tkeep, m_tdata};

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            in_frame = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (frame_dropped) n_drops++;
            if (in_frame) check_eq("no_gap", 64'(m_tvalid), 64'd1);
            if (prev_stall) check_eq("stall_hold", {m_tvalid, beat}, {1'b1, prev_beat});
            if (m_tvalid && m_tready) begin
                check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check_eq("beat", 64'(beat), 64'(exp_q.pop_front()));
                in_frame = !m_tlast;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat = beat;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_frame(input int len, input int gap, input logic [31:0] base,
                              input logic [3:0] keep_last, input bit has_last, input bit keep,
                              input int drop_at);
        for (int i = 0; i < len; i++) begin
            logic last;
            last = has_last && (i == len - 1);
            s_tvalid = 1'b1;
            s_tdata = base + 32'(i);
            s_tkeep = last ? keep_last : 4'hF;
            s_tlast = last;
            if (keep) exp_q.push_back({last, s_tkeep, s_tdata});
            tick();
            if (drop_at >= 0) check_eq("drop_pulse", 64'(frame_dropped), 64'(i == drop_at));
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
            repeat (gap) tick();
        end
        if (keep && has_last) tot += len;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int drops0;
        tick();
        tick();
        check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_tready", 64'(s_tready), 64'd0);
        check_eq("rst_dropped", 64'(frame_dropped), 64'd0);
        check_eq("rst_stored", 64'(frames_stored), 64'd0);
        check_eq("rst_tdata", 64'(m_tdata), 64'd0);
        reset = 1'b0;
        m_tready = 1'b1;
        tick();

        // 16-beat frame, latency to first beat, then a gap-free stream
        send_frame(16, 0, 32'd0, 4'b0011, 1'b1, 1'b1, -1);
        check_eq("t1_stored_1", 64'(frames_stored), 64'd1);
        tick();
        check_eq("t1_n1_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        check_eq("t1_n2_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        check_eq("t1_n3_tvalid", 64'(m_tvalid), 64'd1);
        check_eq("t1_first_beat", 64'(beat), {27'd0, 1'b0, 4'hF, 32'd0});
        wait_drain(100);
        check_eq("t1_stored_0", 64'(frames_stored), 64'd0);

        // 1-beat frame obeys the same latency
        send_frame(1, 0, 32'hAB, 4'b0001, 1'b1, 1'b1, -1);
        tick();
        tick();
        check_eq("t1b_n2_tvalid", 64'(m_tvalid), 64'd0);
        tick();
        check_eq("t1b_n3_tvalid", 64'(m_tvalid), 64'd1);
        wait_drain(50);

        // Sparse input, largest frame that still fits with room to spare
        send_frame(DEPTH - 2, 2, 32'h100, 4'b0111, 1'b1, 1'b1, -1);
        wait_drain(200);

        // Oversized frame dropped on beat 17, next frame delivered alone
        drops0 = n_drops;
        send_frame(20, 0, 32'h200, 4'hF, 1'b1, 1'b0, 16);
        tick();
        check_eq("t3_wr_ptr", 64'(dut.wr_ptr), 64'(tot % (2 * DEPTH)));
        check_eq("t3_commit_ptr", 64'(dut.commit_ptr), 64'(tot % (2 * DEPTH)));
        send_frame(4, 0, 32'h300, 4'b0001, 1'b1, 1'b1, -1);
        wait_drain(100);
        check_eq("t3_drops", 64'(n_drops - drops0), 64'd1);

        // Back-to-back 3-beat frames under random backpressure
        drops0 = n_drops;
        rand_rdy = 1'b1;
        for (int f = 0; f < 6; f++) send_frame(3, 0, 32'h400 + 32'(f * 16), 4'b0011, 1'b1, 1'b1, -1);
        check_eq("t4_stored_bound", 64'(frames_stored <= 5'd6), 64'd1);
        wait_drain(2000);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        tick();
        check_eq("t4_stored_0", 64'(frames_stored), 64'd0);
        check_eq("t4_drops", 64'(n_drops - drops0), 64'd0);

        // Reset mid-output and mid-input frame
        m_tready = 1'b0;
        send_frame(6, 0, 32'h500, 4'hF, 1'b1, 1'b1, -1);
        send_frame(3, 0, 32'h550, 4'hF, 1'b0, 1'b0, -1);
        repeat (3) tick();
        m_tready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_eq("t5_tready_in_rst", 64'(s_tready), 64'd0);
        tick();
        reset = 1'b0;
        tot = 0;
        check_eq("t5_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("t5_stored", 64'(frames_stored), 64'd0);
        check_eq("t5_tdata", 64'(m_tdata), 64'd0);
        check_eq("t5_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        send_frame(5, 0, 32'h580, 4'b0111, 1'b1, 1'b1, -1);
        wait_drain(100);

        // Exact fill, held with backpressure, then a follow-on frame as space frees
        drops0 = n_drops;
        m_tready = 1'b0;
        send_frame(DEPTH, 0, 32'h600, 4'b0111, 1'b1, 1'b1, -1);
        repeat (6) tick();
        check_eq("t6_stored", 64'(frames_stored), 64'd1);
        check_eq("t6_tvalid", 64'(m_tvalid), 64'd1);
        check_eq("t6_head", 64'(m_tdata), 64'h600);
        m_tready = 1'b1;
        tick();
        send_frame(4, 0, 32'h700, 4'b0001, 1'b1, 1'b1, -1);
        wait_drain(200);
        check_eq("t6_drops", 64'(n_drops - drops0), 64'd0);
        check_eq("t6_stored_0", 64'(frames_stored), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
